turf_udp_rdwr_req: RTL and testbench



---
 rtl/turf_udp_pkg.sv | 36 +++
 rtl/turf_udp_beat_buffer.sv | 28 ++
 rtl/turf_udp_rdwr_req.sv | 174 +++++++++++++++++
 tb/tb_turf_udp_rdwr_req.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_udp_pkg.sv
// Shared constants and types for the TURF UDP register request path.
// Holds the port numbers, header/payload field positions and the request FSM states.
package turf_udp_pkg;

    localparam logic [15:0] UDP_PORT_TR = 16'd21618;
    localparam logic [15:0] UDP_PORT_TW = 16'd21623;
    localparam logic [15:0] UDP_PORT_TA = 16'd21601;
    localparam logic [15:0] UDP_PORT_TN = 16'd21614;
    localparam logic [15:0] UDP_PORT_TC = 16'd21603;
    localparam logic [15:0] UDP_PORT_TE = 16'd21605;

    localparam int HDR_IP_MSB   = 63;
    localparam int HDR_IP_LSB   = 32;
    localparam int HDR_PORT_MSB = 31;
    localparam int HDR_PORT_LSB = 16;
    localparam int HDR_LEN_MSB  = 15;
    localparam int HDR_LEN_LSB  = 0;

    localparam int PAY_ADR_MSB  = 59;
    localparam int PAY_ADR_LSB  = 32;
    localparam int PAY_DAT_MSB  = 31;
    localparam int PAY_DAT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HDR,
        ST_PAYLOAD
    } req_state_e;

    // Every payload beat is one 64-bit word, so the UDP length is beats * 8.
    function automatic logic [15:0] beats_to_bytes(input logic [15:0] beats);
        return beats << 3;
    endfunction

endpackage

// File: rtl/turf_udp_beat_buffer.sv
// Simple dual-port beat store with a registered read port (maps onto block RAM).
// Read data only changes when rd_en_i is high, so the consumer can hold it during stalls.
module turf_udp_beat_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 60,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/turf_udp_rdwr_req.sv
// Batches register read/write commands into Tr/Tw UDP request packets.
// A packet is fully buffered before its header goes out because the header carries the length.
module turf_udp_rdwr_req
    import turf_udp_pkg::*;
#(
    parameter int          MAX_BEATS = 16,
    parameter int          TIMEOUT   = 256,
    parameter logic [15:0] SRC_PORT  = 16'd21620,
    parameter logic [15:0] TR_PORT   = UDP_PORT_TR,
    parameter logic [15:0] TW_PORT   = UDP_PORT_TW
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] dest_ip,
    input  logic [27:0] s_cmd_adr,
    input  logic [31:0] s_cmd_dat,
    input  logic        s_cmd_wr,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    output logic [63:0] m_hdr_tdata,
    output logic [15:0] m_hdr_tuser,
    output logic        m_hdr_tvalid,
    input  logic        m_hdr_tready,
    output logic [63:0] m_payload_tdata,
    output logic [7:0]  m_payload_tkeep,
    output logic        m_payload_tvalid,
    input  logic        m_payload_tready,
    output logic        m_payload_tlast
);

    localparam int AW  = $clog2(MAX_BEATS);
    localparam int CW  = AW + 1;
    localparam int TMW = $clog2(TIMEOUT + 1);

    req_state_e      state_q;
    logic            kind_q;
    logic [CW-1:0]   count_q;
    logic [TMW-1:0]  timer_q;
    logic [AW-1:0]   rdptr_q;
    logic            hdr_valid_q;
    logic [63:0]     hdr_data_q;
    logic            pay_valid_q;

    logic            cmd_ready;
    logic            accept;
    logic            close;
    logic [CW-1:0]   count_inc;
    logic [CW-1:0]   close_beats;
    logic            pkt_kind;
    logic [63:0]     hdr_word;
    logic            hdr_hs;
    logic            pay_hs;
    logic            pay_last;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [59:0]     rd_data;

    assign count_inc = count_q + 1'b1;
    assign accept    = s_cmd_tvalid & s_cmd_tready;
    assign hdr_hs    = hdr_valid_q & m_hdr_tready;
    assign pay_hs    = pay_valid_q & m_payload_tready;
    assign pay_last  = ({1'b0, rdptr_q} == (count_q - 1'b1));

    // Ready is held low while reset is asserted so nothing is accepted into a cleared FSM.
    assign s_cmd_tready = cmd_ready & aresetn;

    always_comb begin
        cmd_ready   = 1'b0;
        close       = 1'b0;
        pkt_kind    = kind_q;
        close_beats = accept ? count_inc : count_q;
        hdr_word    = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                pkt_kind  = s_cmd_wr;
                close     = accept && (count_inc == CW'(MAX_BEATS));
            end
            ST_COLLECT: begin
                cmd_ready = (s_cmd_wr == kind_q) && (count_q < CW'(MAX_BEATS));
                close     = (accept && (count_inc == CW'(MAX_BEATS)))
                          || (s_cmd_tvalid && (s_cmd_wr != kind_q))
                          || (!accept && (timer_q == TMW'(TIMEOUT - 1)));
            end
            default: ;
        endcase
        hdr_word[HDR_IP_MSB:HDR_IP_LSB]     = dest_ip;
        hdr_word[HDR_PORT_MSB:HDR_PORT_LSB] = pkt_kind ? TW_PORT : TR_PORT;
        hdr_word[HDR_LEN_MSB:HDR_LEN_LSB]   = beats_to_bytes(16'(close_beats));
    end

    // Prefetch beat 0 on the header handshake and the next beat on each non-final payload handshake.
    assign rd_en   = hdr_hs | (pay_hs & ~pay_last);
    assign rd_addr = hdr_hs ? '0 : AW'(rdptr_q + 1'b1);

    turf_udp_beat_buffer #(
        .DEPTH (MAX_BEATS),
        .WIDTH (60)
    ) u_buf (
        .clk_i     (aclk),
        .wr_en_i   (accept),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_data_i ({s_cmd_adr, s_cmd_wr ? s_cmd_dat : 32'h0}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            kind_q      <= 1'b0;
            count_q     <= '0;
            timer_q     <= '0;
            rdptr_q     <= '0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            pay_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        kind_q  <= s_cmd_wr;
                        count_q <= count_inc;
                        timer_q <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        count_q <= count_inc;
                        timer_q <= '0;
                    end else if (!close) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_HDR: begin
                    if (hdr_hs) begin
                        hdr_valid_q <= 1'b0;
                        pay_valid_q <= 1'b1;
                        rdptr_q     <= '0;
                        state_q     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_hs) begin
                        if (pay_last) begin
                            pay_valid_q <= 1'b0;
                            count_q     <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rdptr_q <= rdptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (close) begin
                hdr_data_q  <= hdr_word;
                hdr_valid_q <= 1'b1;
                state_q     <= ST_HDR;
            end
        end
    end

    assign m_hdr_tdata      = hdr_data_q;
    assign m_hdr_tuser      = SRC_PORT;
    assign m_hdr_tvalid     = hdr_valid_q;
    assign m_payload_tvalid = pay_valid_q;
    assign m_payload_tdata  = pay_valid_q ? {4'b0, rd_data} : 64'h0;
    assign m_payload_tkeep  = pay_valid_q ? 8'hFF : 8'h00;
    assign m_payload_tlast  = pay_valid_q & pay_last;

endmodule

// File: tb/tb_turf_udp_rdwr_req.sv
// Directed bench for turf_udp_rdwr_req with a scoreboard of expected headers and beats.
// A negedge monitor pops and compares on every output handshake.
module tb_turf_udp_rdwr_req;

    localparam int          TIMEOUT = 256;
    localparam logic [15:0] SRC     = 16'd21620;
    localparam logic [15:0] TRP     = 16'd21618;
    localparam logic [15:0] TWP     = 16'd21623;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] dest_ip;
    logic [27:0] s_cmd_adr;
    logic [31:0] s_cmd_dat;
    logic        s_cmd_wr;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [63:0] m_hdr_tdata;
    logic [15:0] m_hdr_tuser;
    logic        m_hdr_tvalid;
    logic        m_hdr_tready;
    logic [63:0] m_payload_tdata;
    logic [7:0]  m_payload_tkeep;
    logic        m_payload_tvalid;
    logic        m_payload_tready;
    logic        m_payload_tlast;

    turf_udp_rdwr_req dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .dest_ip          (dest_ip),
        .s_cmd_adr        (s_cmd_adr),
        .s_cmd_dat        (s_cmd_dat),
        .s_cmd_wr         (s_cmd_wr),
        .s_cmd_tvalid     (s_cmd_tvalid),
        .s_cmd_tready     (s_cmd_tready),
        .m_hdr_tdata      (m_hdr_tdata),
        .m_hdr_tuser      (m_hdr_tuser),
        .m_hdr_tvalid     (m_hdr_tvalid),
        .m_hdr_tready     (m_hdr_tready),
        .m_payload_tdata  (m_payload_tdata),
        .m_payload_tkeep  (m_payload_tkeep),
        .m_payload_tvalid (m_payload_tvalid),
        .m_payload_tready (m_payload_tready),
        .m_payload_tlast  (m_payload_tlast)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    logic [63:0] exp_hdr_q [$];
    logic [64:0] exp_pay_q [$];
    int checks = 0;
    int passes = 0;
    int pay_popped = 0;
    bit toggle_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] hdr(input logic [31:0] ip, input bit wr, input int nbeats);
        return {ip, wr ? TWP : TRP, 16'(nbeats * 8)};
    endfunction

    function automatic logic [64:0] beat(input bit last, input bit wr, input logic [27:0] adr,
                                         input logic [31:0] dat);
        return {last, 4'b0, adr, wr ? dat : 32'h0};
    endfunction

    // Scoreboard monitor
    initial begin
        bit          hstall = 1'b0;
        bit          pstall = 1'b0;
        logic [63:0] hprev = '0;
        logic [64:0] pprev = '0;
        logic [63:0] eh;
        logic [64:0] ep;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hstall = 1'b0;
                pstall = 1'b0;
            end else begin
                if (hstall) begin
                    chk("hdr_hold_valid", m_hdr_tvalid, 1'b1);
                    chk("hdr_hold_data", m_hdr_tdata, hprev);
                end
                if (pstall) begin
                    chk("pay_hold_valid", m_payload_tvalid, 1'b1);
                    chk("pay_hold_data", {m_payload_tlast, m_payload_tdata}, pprev);
                end
                if (m_hdr_tvalid || m_payload_tvalid)
                    chk("cmd_ready_busy", s_cmd_tready, 1'b0);
                if (m_hdr_tvalid && m_hdr_tready) begin
                    if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 0, 1);
                    else begin
                        eh = exp_hdr_q.pop_front();
                        chk("hdr_data", m_hdr_tdata, eh);
                        chk("hdr_tuser", m_hdr_tuser, SRC);
                    end
                end
                if (m_payload_tvalid && m_payload_tready) begin
                    pay_popped++;
                    if (exp_pay_q.size() == 0) chk("pay_unexpected", 0, 1);
                    else begin
                        ep = exp_pay_q.pop_front();
                        chk("pay_beat", {m_payload_tlast, m_payload_tdata}, ep);
                        chk("pay_keep", m_payload_tkeep, 8'hFF);
                    end
                end
                hstall = m_hdr_tvalid && !m_hdr_tready;
                hprev  = m_hdr_tdata;
                pstall = m_payload_tvalid && !m_payload_tready;
                pprev  = {m_payload_tlast, m_payload_tdata};
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (toggle_en) m_payload_tready = !m_payload_tready;
        end
    end

    task automatic send_cmd(input bit wr, input logic [27:0] adr, input logic [31:0] dat,
                            output int acc_cyc);
        int n = 0;
        s_cmd_wr     = wr;
        s_cmd_adr    = adr;
        s_cmd_dat    = dat;
        s_cmd_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_cmd_tready) begin
            n++;
            if (n > 2000) begin
                chk("cmd_accept_timeout", n, 0);
                break;
            end
            @(negedge aclk);
        end
        acc_cyc = cyc;
        $display("cmd wr=%0d adr=0x%0h dat=0x%0h accepted at cycle %0d", wr, adr, dat, cyc);
        @(posedge aclk);
        #1;
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_hdr_q.size() != 0 || exp_pay_q.size() != 0) begin
            @(negedge aclk);
            n++;
            if (n > 5000) begin
                chk("drain_timeout", exp_hdr_q.size() + exp_pay_q.size(), 0);
                exp_hdr_q.delete();
                exp_pay_q.delete();
                break;
            end
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic wait_hdr_valid(output bit ok);
        int n = 0;
        ok = 1'b1;
        do begin
            @(negedge aclk);
            n++;
            if (n > 1000) begin
                chk("hdr_valid_timeout", n, 0);
                ok = 1'b0;
                break;
            end
        end while (!m_hdr_tvalid);
    endtask

    initial begin
        int acc;
        int base;
        int n;
        bit ok;
        aresetn          = 1'b0;
        dest_ip          = 32'h0;
        s_cmd_adr        = '0;
        s_cmd_dat        = '0;
        s_cmd_wr         = 1'b0;
        s_cmd_tvalid     = 1'b0;
        m_hdr_tready     = 1'b1;
        m_payload_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_cmd_ready", s_cmd_tready, 1'b0);
        chk("rst_hdr_valid", m_hdr_tvalid, 1'b0);
        chk("rst_pay_valid", m_payload_tvalid, 1'b0);
        chk("rst_pay_last", m_payload_tlast, 1'b0);
        chk("rst_hdr_data", m_hdr_tdata, 64'h0);
        chk("rst_pay_data", m_payload_tdata, 64'h0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Three writes, closed by the idle timeout
        dest_ip = 32'hC0A8_0001;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b1, 3));
        exp_pay_q.push_back(beat(1'b0, 1'b1, 28'h10, 32'hA));
        exp_pay_q.push_back(beat(1'b0, 1'b1, 28'h14, 32'hB));
        exp_pay_q.push_back(beat(1'b1, 1'b1, 28'h18, 32'hC));
        send_cmd(1'b1, 28'h10, 32'hA, acc);
        send_cmd(1'b1, 28'h14, 32'hB, acc);
        send_cmd(1'b1, 28'h18, 32'hC, acc);
        wait_drain();

        // Twenty reads: one full packet, then a 4-beat one after timeout
        dest_ip = 32'h0A00_0002;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b0, 16));
        exp_hdr_q.push_back(hdr(dest_ip, 1'b0, 4));
        for (int i = 0; i < 20; i++)
            exp_pay_q.push_back(beat((i == 15) || (i == 19), 1'b0, 28'(28'h100 + 4 * i), 32'h0));
        for (int i = 0; i < 20; i++)
            send_cmd(1'b0, 28'(28'h100 + 4 * i), 32'(32'hDEAD_0000 + i), acc);
        wait_drain();

        // Kind change closes the read packet; the write waits for the next one
        dest_ip = 32'h0A00_0003;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b0, 2));
        exp_hdr_q.push_back(hdr(dest_ip, 1'b1, 1));
        exp_pay_q.push_back(beat(1'b0, 1'b0, 28'h200, 32'h0));
        exp_pay_q.push_back(beat(1'b1, 1'b0, 28'h204, 32'h0));
        exp_pay_q.push_back(beat(1'b1, 1'b1, 28'h208, 32'h55));
        send_cmd(1'b0, 28'h200, 32'h1, acc);
        send_cmd(1'b0, 28'h204, 32'h2, acc);
        send_cmd(1'b1, 28'h208, 32'h55, acc);
        wait_drain();

        // Header backpressure, then toggling payload ready
        dest_ip      = 32'h0A00_0004;
        m_hdr_tready = 1'b0;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b1, 2));
        exp_pay_q.push_back(beat(1'b0, 1'b1, 28'h300, 32'h11));
        exp_pay_q.push_back(beat(1'b1, 1'b1, 28'h304, 32'h22));
        send_cmd(1'b1, 28'h300, 32'h11, acc);
        send_cmd(1'b1, 28'h304, 32'h22, acc);
        wait_hdr_valid(ok);
        repeat (10) @(posedge aclk);
        #1;
        m_hdr_tready = 1'b1;
        toggle_en    = 1'b1;
        wait_drain();
        toggle_en = 1'b0;
        @(posedge aclk);
        #2;
        m_payload_tready = 1'b1;

        // Reset in the middle of a 5-beat payload
        dest_ip = 32'h0A00_0005;
        base    = pay_popped;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b1, 5));
        for (int i = 0; i < 5; i++)
            exp_pay_q.push_back(beat(i == 4, 1'b1, 28'(28'h400 + 4 * i), 32'(32'h500 + i)));
        for (int i = 0; i < 5; i++)
            send_cmd(1'b1, 28'(28'h400 + 4 * i), 32'(32'h500 + i), acc);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!m_payload_tvalid && n < 1000);
        chk("pay_valid_seen", m_payload_tvalid, 1'b1);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("midrst_hdr_valid", m_hdr_tvalid, 1'b0);
        chk("midrst_pay_valid", m_payload_tvalid, 1'b0);
        chk("midrst_pay_last", m_payload_tlast, 1'b0);
        chk("midrst_pay_data", m_payload_tdata, 64'h0);
        chk("midrst_cmd_ready", s_cmd_tready, 1'b0);
        chk("midrst_beats_sent", pay_popped - base, 2);
        chk("midrst_beats_left", exp_pay_q.size(), 3);
        exp_pay_q.delete();
        exp_hdr_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b0, 2));
        exp_pay_q.push_back(beat(1'b0, 1'b0, 28'h600, 32'h0));
        exp_pay_q.push_back(beat(1'b1, 1'b0, 28'h604, 32'h0));
        send_cmd(1'b0, 28'h600, 32'h0, acc);
        send_cmd(1'b0, 28'h604, 32'h0, acc);
        wait_drain();

        // Single read: header latency from the accept cycle
        dest_ip = 32'h0A00_0006;
        exp_hdr_q.push_back(hdr(dest_ip, 1'b0, 1));
        exp_pay_q.push_back(beat(1'b1, 1'b0, 28'h700, 32'h0));
        send_cmd(1'b0, 28'h700, 32'h9, acc);
        wait_hdr_valid(ok);
        if (ok) chk("hdr_latency", cyc - acc, TIMEOUT + 1);
        wait_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
